// File: rtl/bp_pkg.sv
// Shared types for the branch-resolution path: the per-instruction
// prediction record and the resolver's run/recover state.
package bp_pkg;

   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_target;
   } pred_rec_t;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } resolve_state_t;

   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
      return pc + 32'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of prediction records. The head is read combinationally so that
// EX can compare against it in the resolving cycle. A flush overrides push and pop.
module pred_fifo
   import bp_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type rec_t = pred_rec_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  rec_t push_rec,
   input  logic pop,
   input  logic flush,
   output rec_t head_rec,
   output logic full,
   output logic empty,
   output logic full_next
);
   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wr_ptr_reg, wr_ptr_next;
   logic [AW:0] rd_ptr_reg, rd_ptr_next;
   rec_t        mem [DEPTH];

   function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
      return (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
   endfunction

   always_comb begin
      wr_ptr_next = wr_ptr_reg + (AW+1)'(push);
      rd_ptr_next = rd_ptr_reg + (AW+1)'(pop);
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end
   end

   assign full      = ptr_full(wr_ptr_reg, rd_ptr_reg);
   assign empty     = (wr_ptr_reg == rd_ptr_reg);
   assign full_next = ptr_full(wr_ptr_next, rd_ptr_next);
   assign head_rec  = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_rec;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolver: matches EX outcomes against the queued fetch
// predictions, updates the predictor, and redirects and recovers on mispredict.
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_valid,
   output logic        push_ready,
   input  logic [31:0] push_pc,
   input  logic        push_pred_taken,
   input  logic [31:0] push_pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   output logic        upd_branch,
   output logic        upd_taken,
   output logic [31:0] upd_pc,
   output logic [31:0] upd_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        order_err,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);
   localparam int CW = $clog2(RECOVER_CYCLES + 1);

   resolve_state_t state_reg;
   logic [CW-1:0]  recover_cnt_reg;
   logic           push_ready_reg;
   logic           upd_branch_reg;
   logic           upd_taken_reg;
   logic [31:0]    upd_pc_reg;
   logic [31:0]    upd_target_reg;
   logic           redirect_valid_reg;
   logic [31:0]    redirect_pc_reg;
   logic           order_err_reg;
   logic [31:0]    stat_branches_reg;
   logic [31:0]    stat_mispredicts_reg;

   pred_rec_t push_rec;
   pred_rec_t head_rec;
   pred_rec_t pred_rec;
   logic      fifo_full;
   logic      fifo_empty;
   logic      fifo_full_next;
   logic      resolve;
   logic      pop;
   logic      push_acc;
   logic      mispredict;

   assign push_rec = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};

   // With nothing queued, EX is judged against an implicit not-taken prediction.
   always_comb begin
      pred_rec = head_rec;
      if (fifo_empty) begin
         pred_rec = '0;
      end
   end

   assign resolve    = (state_reg == RUN) && ex_valid;
   assign pop        = resolve && !fifo_empty;
   assign push_acc   = push_valid && push_ready_reg && !fifo_full;
   assign mispredict = resolve &&
                       ((pred_rec.pred_taken != ex_taken) ||
                        (ex_taken && (pred_rec.pred_target != ex_target)));

   pred_fifo #(
      .DEPTH (DEPTH),
      .rec_t (pred_rec_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_acc),
      .push_rec  (push_rec),
      .pop       (pop),
      .flush     (mispredict),
      .head_rec  (head_rec),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .full_next (fifo_full_next)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg            <= RUN;
         recover_cnt_reg      <= '0;
         push_ready_reg       <= 1'b0;
         upd_branch_reg       <= 1'b0;
         upd_taken_reg        <= 1'b0;
         upd_pc_reg           <= '0;
         upd_target_reg       <= '0;
         redirect_valid_reg   <= 1'b0;
         redirect_pc_reg      <= '0;
         order_err_reg        <= 1'b0;
         stat_branches_reg    <= '0;
         stat_mispredicts_reg <= '0;
      end else begin
         upd_branch_reg     <= resolve;
         redirect_valid_reg <= mispredict;

         if (resolve) begin
            upd_taken_reg  <= ex_taken;
            upd_pc_reg     <= ex_pc;
            upd_target_reg <= ex_target;
            if (stat_branches_reg != '1) begin
               stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (!fifo_empty && (head_rec.pc != ex_pc)) begin
               order_err_reg <= 1'b1;
            end
         end

         if (mispredict) begin
            redirect_pc_reg <= ex_taken ? ex_target : next_seq_pc(ex_pc);
            if (stat_mispredicts_reg != '1) begin
               stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
         end

         // push_ready is registered from the next-cycle state and occupancy.
         case (state_reg)
            RUN: begin
               if (mispredict) begin
                  state_reg       <= RECOVER;
                  recover_cnt_reg <= CW'(RECOVER_CYCLES);
                  push_ready_reg  <= 1'b0;
               end else begin
                  push_ready_reg  <= !fifo_full_next;
               end
            end
            RECOVER: begin
               if (recover_cnt_reg == CW'(1)) begin
                  state_reg       <= RUN;
                  recover_cnt_reg <= '0;
                  push_ready_reg  <= !fifo_full_next;
               end else begin
                  recover_cnt_reg <= recover_cnt_reg - CW'(1);
                  push_ready_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg      <= RUN;
               push_ready_reg <= 1'b0;
            end
         endcase
      end
   end

   assign push_ready       = push_ready_reg;
   assign upd_branch       = upd_branch_reg;
   assign upd_taken        = upd_taken_reg;
   assign upd_pc           = upd_pc_reg;
   assign upd_target       = upd_target_reg;
   assign redirect_valid   = redirect_valid_reg;
   assign redirect_pc      = redirect_pc_reg;
   assign order_err        = order_err_reg;
   assign stat_branches    = stat_branches_reg;
   assign stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and random stimulus for branch_resolve_unit, checked each cycle
// against a queue-based reference model of the resolution rules.
module tb_branch_resolve_unit;
   localparam int DEPTH   = 8;
   localparam int RECOVER = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid;
   logic        push_ready;
   logic [31:0] push_pc;
   logic        push_pred_taken;
   logic [31:0] push_pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        upd_branch;
   logic        upd_taken;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        order_err;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   branch_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYCLES(RECOVER)) dut (
      .clk              (clk),
      .rst              (rst),
      .push_valid       (push_valid),
      .push_ready       (push_ready),
      .push_pc          (push_pc),
      .push_pred_taken  (push_pred_taken),
      .push_pred_target (push_pred_target),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .upd_branch       (upd_branch),
      .upd_taken        (upd_taken),
      .upd_pc           (upd_pc),
      .upd_target       (upd_target),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .order_err        (order_err),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } mrec_t;

   mrec_t       mq[$];
   int          rec_left;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic        e_ready, e_upd, e_upd_taken, e_redir, e_oerr;
   logic [31:0] e_upd_pc, e_upd_tgt, e_redir_pc, e_br, e_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
      end
   endtask

   // Reference model: applies one clock edge worth of the resolution rules.
   task automatic model_edge();
      mrec_t p;
      logic  acc;
      logic  mis;
      if (!rst) begin
         mq.delete();
         rec_left = 0;
         e_ready = 0; e_upd = 0; e_upd_taken = 0; e_upd_pc = 0; e_upd_tgt = 0;
         e_redir = 0; e_redir_pc = 0; e_oerr = 0; e_br = 0; e_mis = 0;
         return;
      end
      acc = push_valid && e_ready;
      mis = 0;
      e_upd = 0;
      e_redir = 0;
      if (rec_left == 0) begin
         if (ex_valid) begin
            p = '{pc: 32'h0, taken: 1'b0, target: 32'h0};
            if (mq.size() > 0) begin
               p = mq.pop_front();
               if (p.pc != ex_pc) e_oerr = 1;
            end
            e_upd = 1;
            e_upd_taken = ex_taken;
            e_upd_pc = ex_pc;
            e_upd_tgt = ex_target;
            if (e_br != 32'hFFFF_FFFF) e_br = e_br + 1;
            mis = (p.taken != ex_taken) || (p.taken && ex_taken && p.target != ex_target);
         end
         if (acc) mq.push_back('{pc: push_pc, taken: push_pred_taken, target: push_pred_target});
         if (mis) begin
            mq.delete();
            rec_left = RECOVER;
            e_redir = 1;
            e_redir_pc = ex_taken ? ex_target : ex_pc + 32'd4;
            if (e_mis != 32'hFFFF_FFFF) e_mis = e_mis + 1;
         end
      end else begin
         rec_left--;
      end
      e_ready = (rec_left == 0) && (mq.size() < DEPTH);
   endtask

   task automatic step();
      logic was_reset;
      @(posedge clk);
      was_reset = !rst;
      model_edge();
      #1;
      cyc++;
      chk("push_ready", push_ready, e_ready);
      chk("upd_branch", upd_branch, e_upd);
      if (e_upd || was_reset) begin
         chk("upd_taken", upd_taken, e_upd_taken);
         chk("upd_pc", upd_pc, e_upd_pc);
         chk("upd_target", upd_target, e_upd_tgt);
      end
      chk("redirect_valid", redirect_valid, e_redir);
      if (e_redir || was_reset) chk("redirect_pc", redirect_pc, e_redir_pc);
      chk("order_err", order_err, e_oerr);
      chk("stat_branches", stat_branches, e_br);
      chk("stat_mispredicts", stat_mispredicts, e_mis);
      if (e_upd)
         $display("cyc=%0d resolve pc=%h taken=%0d redirect=%0d rpc=%h", cyc, e_upd_pc, e_upd_taken, e_redir, e_redir_pc);
   endtask

   task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                        input logic ev, input logic [31:0] epc, input logic et, input logic [31:0] etg);
      push_valid = pv; push_pc = ppc; push_pred_taken = pt; push_pred_target = ptg;
      ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etg;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      idle();
      rec_left = 0;
      e_ready = 0;
      step(); step();
      rst = 1'b1;
      step();
      chk("ready_after_reset", push_ready, 32'd1);

      // Correctly predicted taken branch
      drive(1, 32'h100, 1, 32'h200, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 1, 32'h100, 1, 32'h200); step();
      chk("t1_upd_pc", upd_pc, 32'h100);
      chk("t1_redirect", redirect_valid, 32'd0);
      chk("t1_branches", stat_branches, 32'd1);

      // Predicted not-taken, actually taken
      drive(1, 32'h104, 0, 32'h0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 1, 32'h104, 1, 32'h300); step();
      chk("t2_redirect_pc", redirect_pc, 32'h300);
      chk("t2_mispredicts", stat_mispredicts, 32'd1);
      chk("t2_ready0_a", push_ready, 32'd0);
      idle(); step();
      chk("t2_ready0_b", push_ready, 32'd0);
      step();
      chk("t2_ready1", push_ready, 32'd1);

      // Wrong target, then predicted taken but not taken
      drive(1, 32'h108, 1, 32'h400, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 1, 32'h108, 1, 32'h404); step();
      chk("t3_redirect_pc", redirect_pc, 32'h404);
      idle(); step(); step();
      drive(1, 32'h10C, 1, 32'h500, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 1, 32'h10C, 0, 32'h0); step();
      chk("t3b_redirect_pc", redirect_pc, 32'h110);
      idle(); step(); step();

      // Fill to DEPTH, then push while resolving the head
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 32'h1000 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0); step();
      end
      chk("full_ready0", push_ready, 32'd0);
      drive(1, 32'h2000, 0, 32'h0, 1, 32'h1000, 0, 32'h0); step();
      chk("full_pop_ready1", push_ready, 32'd1);
      for (int i = 1; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, 1, 32'h1000 + 32'(4 * i), 0, 32'h0); step();
      end
      chk("drain_no_redirect", redirect_valid, 32'd0);
      idle(); step();

      // Out-of-order resolve, then resolve with an empty queue
      drive(1, 32'h200, 0, 32'h0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 1, 32'h204, 0, 32'h0); step();
      chk("order_err_set", order_err, 32'd1);
      drive(0, 0, 0, 0, 1, 32'h300, 1, 32'h800); step();
      chk("empty_redirect_pc", redirect_pc, 32'h800);
      idle(); step(); step();
      chk("order_err_sticky", order_err, 32'd1);

      // Reset during recovery
      drive(0, 0, 0, 0, 1, 32'h500, 1, 32'h900); step();
      idle(); step();
      rst = 1'b0; step();
      chk("rst_mid_recover_ready", push_ready, 32'd0);
      rst = 1'b1; step();
      chk("rst_recover_ready1", push_ready, 32'd1);

      // Random traffic, mostly in order with occasional mispredicts
      for (int n = 0; n < 600; n++) begin
         logic [31:0] epc, etg;
         logic        et;
         if (mq.size() > 0 && $urandom_range(0, 15) != 0) begin
            epc = mq[0].pc;
            et  = ($urandom_range(0, 7) != 0) ? mq[0].taken : ~mq[0].taken;
            etg = ($urandom_range(0, 7) != 0) ? mq[0].target : 32'h0000_0C00;
         end else begin
            epc = {$urandom_range(0, 255), 2'b00};
            et  = 1'($urandom_range(0, 1));
            etg = {$urandom_range(0, 255), 2'b00};
         end
         drive(1'($urandom_range(0, 3) != 0), 32'h4000 + 32'(4 * n), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80,
               1'($urandom_range(0, 1)), epc, et, etg);
         step();
      end
      idle(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart to the fetch-stage branch predictor.
- Buffers the prediction fetch made for each control-flow instruction in an in-order tracking queue.
- When EX resolves the instruction, compares prediction against outcome and drives the predictor update bus (branch/taken/pc/target).
- On mispredict: issues a one-cycle redirect, flushes all younger records, and blocks for a fixed recovery window.

Parameters:
- DEPTH, 8, tracking-queue entries; power of two, ≥2.
- RECOVER_CYCLES, 2, cycles after a redirect during which push and EX input are ignored; ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-low reset; state clears on the clk edge where rst==0.
- push_valid  in  1  fetch offers a prediction record.
- push_ready  out  1  queue can accept a record.
- push_pc  in  32  PC of the predicted instruction.
- push_pred_taken  in  1  predicted direction.
- push_pred_target  in  32  predicted target; ignored when not taken.
- ex_valid  in  1  EX resolves one control-flow instruction this cycle.
- ex_pc  in  32  PC of the resolved instruction.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual taken target.
- upd_branch  out  1  predictor update strobe.
- upd_taken  out  1  actual direction.
- upd_pc  out  32  resolved PC.
- upd_target  out  32  actual target.
- redirect_valid  out  1  one-cycle mispredict redirect.
- redirect_pc  out  32  correct next PC.
- order_err  out  1  sticky; head PC ≠ ex_pc.
- stat_branches  out  32  resolved count, saturating.
- stat_mispredicts  out  32  mispredict count, saturating.

Behaviour:
- Reset (rst==0), all outputs 0:
  - queue empty, push_ready=0, FSM=RUN; counters and order_err cleared.
  - push_ready becomes 1 on the first cycle after rst returns high.
- Queue:
  - Head/tail pointers are log2(DEPTH)+1 bits wide, with a wrap bit.
  - Full when indices are equal and wrap bits differ; empty when the pointers are equal.
  - push_ready = !full && state==RUN. It does not depend on a same-cycle pop, so there is no bypass.
  - A push is accepted on push_valid && push_ready.
- Resolution (state==RUN && ex_valid):
  - Pop the head if the queue is non-empty.
  - If empty, use an implicit record {pred_taken=0}.
  - If the head is non-empty and head.pc ≠ ex_pc, set order_err; the comparison still proceeds.
  - Mispredict when pred_taken ≠ ex_taken, or when both are taken and pred_target ≠ ex_target.
- Registered outputs, one cycle after ex_valid:
  - upd_branch=1; upd_taken, upd_pc, upd_target copy the EX inputs.
  - upd_branch is low on every other cycle.
  - stat_branches increments in the same cycle as upd_branch; it saturates at 0xFFFF_FFFF.
- On mispredict, next cycle:
  - redirect_valid=1.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, computed mod 2^32.
  - stat_mispredicts increments.
  - The queue is emptied, including any record pushed in the resolving cycle.
  - FSM moves to RECOVER with counter = RECOVER_CYCLES.
- RECOVER:
  - push_ready=0; ex_valid is ignored (no upd, no pop).
  - The counter decrements each cycle; at 1 → RUN.
  - The update and redirect for the resolving instruction are still issued.
- FSM: RUN→RECOVER on mispredict; RECOVER→RUN when the counter expires. There are no other transitions.
- Reset mid-RECOVER or with a non-empty queue clears everything immediately. No pending upd or redirect survives reset.
- Push and ex_valid in the same RUN cycle with no mispredict: both take effect, and occupancy is unchanged.

Decomposition:
- bp_pkg holds:
  - typedef pred_rec_t {pc[31:0], pred_taken, pred_target[31:0]};
  - typedef resolve_state_t {RUN, RECOVER};
  - localparam INSTR_BYTES=4.
- One sub-module, pred_fifo:
  - parameterised DEPTH and type pred_rec_t;
  - push/pop/flush ports, full/empty outputs;
  - synchronous active-low reset.

Test Plan:
- Push {0x100, taken, 0x200}; ex_valid pc=0x100 taken target=0x200
  → next cycle upd_branch=1, upd_pc=0x100, redirect_valid=0, stat_branches=1.
- Push {0x104, not-taken}; resolve taken target=0x300
  → redirect_valid=1, redirect_pc=0x300, stat_mispredicts=1, push_ready=0 for exactly 2 cycles, queue empty afterwards.
- Push {0x108, taken, 0x400}; resolve taken target=0x404
  → mispredict, redirect_pc=0x404. Push {0x10C, taken, 0x500}; resolve not-taken
  → redirect_pc=0x110.
- Push 8 records (DEPTH=8)
  → push_ready=0; a 9th push with concurrent resolve is not accepted that cycle; next cycle push_ready=1 and occupancy=7.
- Push {0x200,…}; ex_valid pc=0x204
  → order_err=1 and stays 1 until reset. ex_valid with empty queue, taken target=0x800
  → treated as predicted not-taken, redirect_pc=0x800.
- Mispredict resolved, then rst=0 during RECOVER
  → next cycle all outputs 0, state RUN, queue empty; push_ready=1 one cycle after rst=1.
